// File: rtl/dsp38_pkg.sv
// Shared DSP38 definitions: operand/result widths, the Z result type and the
// result clamp helper used by the Z collector when DSP38_Z_SAT_EN is defined.
package dsp38_pkg;

  localparam int Z_W       = 38;
  localparam int A_W       = 20;
  localparam int B_W       = 18;
  localparam int ACC_FIR_W = 6;

  typedef logic [Z_W-1:0] dsp38_z_t;

  // Clamp z into a sat_w-bit range. Returns {sat_flag, value}; value is the
  // clamped result sign/zero-extended to Z_W bits, so callers keep the low
  // sat_w bits. Unsigned mode treats the top z bit as magnitude.
  function automatic logic [Z_W:0] dsp38_sat(input dsp38_z_t z,
                                             input int       sat_w,
                                             input logic     is_signed);
    dsp38_z_t      hi;
    dsp38_z_t      lo;
    logic [Z_W:0]  res;
    res = {1'b0, z};
    if (is_signed) begin
      hi = (dsp38_z_t'(1) << (sat_w - 1)) - dsp38_z_t'(1);
      lo = ~hi;
      if ($signed(z) > $signed(hi)) begin
        res = {1'b1, hi};
      end else if ($signed(z) < $signed(lo)) begin
        res = {1'b1, lo};
      end
    end else begin
      hi = (dsp38_z_t'(1) << sat_w) - dsp38_z_t'(1);
      lo = '0;
      if (z > hi) begin
        res = {1'b1, hi};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/dsp38_z_fifo.sv
// Synchronous FIFO for collected Z results. count_o is the source of truth
// for full/empty; pointers wrap modulo DEPTH. Read data is the head entry
// (no bypass: a pushed word is visible the cycle after the push).
module dsp38_z_fifo #(
  parameter int W     = 38,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic [W-1:0]               push_data_i,
  input  logic                       pop_i,
  output logic [W-1:0]               rd_data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push;
  logic             do_pop;

  // Next-state for pointers and occupancy; push and pop are independent.
  always_comb begin
    do_push  = push_i && (count_q != FULL_CNT);
    do_pop   = pop_i && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage and pointer registers; reset clears contents so the head reads 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) mem_q[wr_ptr_q] <= push_data_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rd_data_o = mem_q[rd_ptr_q];
  assign count_o   = count_q;

`ifndef SYNTHESIS
  // Upstream credit accounting must never let a push reach a full FIFO.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push_i && (count_q == FULL_CNT)))
        else $error("dsp38_z_fifo: push while full");
    end
  end
`endif

endmodule

// File: rtl/dsp38_z_collector.sv
// DSP38 Z collector: aligns the DSP38 Z output to its issue strobe through a
// LATENCY-deep valid line, queues results in a FIFO and returns credit to
// the issuer, since the DSP itself cannot stall.
// Optional feature macro: DSP38_Z_SAT_EN (clamp Z into SAT_W bits per entry).
//
// Handshakes: upstream may assert in_valid only while issue_ready=1 (an issue
// with issue_ready=0 is dropped and sets the sticky overflow flag). On the
// output side an entry transfers on a clk edge where out_valid && out_ready;
// while out_valid=1 and out_ready=0 the head (out_data/out_sat) holds.
module dsp38_z_collector
  import dsp38_pkg::*;
#(
  parameter int LATENCY  = 0,
  parameter int DEPTH    = 4,
  parameter int Z_SIGNED = 0,
  parameter int SAT_W    = 20
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       issue_ready,
  input  logic [Z_W-1:0]             z,
  output logic                       out_valid,
  input  logic                       out_ready,
`ifdef DSP38_Z_SAT_EN
  output logic [SAT_W-1:0]           out_data,
`else
  output logic [Z_W-1:0]             out_data,
`endif
  output logic                       out_sat,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int DL_W  = (LATENCY > 0) ? LATENCY : 1;
`ifdef DSP38_Z_SAT_EN
  localparam int FIFO_W = SAT_W + 1;
`else
  localparam int FIFO_W = Z_W;
`endif

  if (LATENCY < 0 || LATENCY > 2) begin : g_bad_latency
    $error("dsp38_z_collector: LATENCY must be 0..2");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("dsp38_z_collector: DEPTH must be a power of two >= 2");
  end
  if (SAT_W < 8 || SAT_W > 37 || Z_SIGNED < 0 || Z_SIGNED > 1) begin : g_bad_sat
    $error("dsp38_z_collector: SAT_W must be 8..37 and Z_SIGNED 0 or 1");
  end

  logic [DL_W-1:0]   vld_q, vld_d;
  logic              overflow_q, overflow_d;
  logic [CNT_W-1:0]  inflight;
  logic [CNT_W:0]    credit_sum;
  logic [CNT_W-1:0]  fifo_count;
  logic              accept;
  logic              push_en;
  logic              pop_en;
  logic [FIFO_W-1:0] push_data;
  logic [FIFO_W-1:0] rd_data;

  // Credit: occupancy plus results still inside the DSP pipeline. Built from
  // registers only, so a pop frees credit one cycle later.
  always_comb begin
    inflight = '0;
    if (LATENCY > 0) begin
      for (int i = 0; i < DL_W; i++) inflight = inflight + CNT_W'(vld_q[i]);
    end
    credit_sum  = {1'b0, fifo_count} + {1'b0, inflight};
    issue_ready = credit_sum < (CNT_W + 1)'(DEPTH);
  end

  // Valid delay line and sticky overflow next-state.
  always_comb begin
    accept     = in_valid && issue_ready;
    vld_d      = '0;
    if (LATENCY > 0) vld_d = (vld_q << 1) | DL_W'(accept);
    overflow_d = overflow_q | (in_valid & ~issue_ready);
  end

  // Delay line and overflow registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      vld_q      <= vld_d;
      overflow_q <= overflow_d;
    end
  end

  assign push_en = (LATENCY == 0) ? accept : vld_q[DL_W-1];
  assign pop_en  = out_valid && out_ready;

`ifdef DSP38_Z_SAT_EN
  logic [Z_W:0] sat_res;
  assign sat_res   = dsp38_sat(z, SAT_W, Z_SIGNED != 0);
  assign push_data = {sat_res[Z_W], sat_res[SAT_W-1:0]};
`else
  assign push_data = z;
`endif

  dsp38_z_fifo #(
    .W     (FIFO_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (reset),
    .push_i      (push_en),
    .push_data_i (push_data),
    .pop_i       (pop_en),
    .rd_data_o   (rd_data),
    .count_o     (fifo_count)
  );

  assign out_valid = (fifo_count != '0);
  assign count     = fifo_count;
  assign overflow  = overflow_q;

`ifdef DSP38_Z_SAT_EN
  assign out_data = rd_data[SAT_W-1:0];
  assign out_sat  = rd_data[FIFO_W-1];
`else
  assign out_data = rd_data;
  assign out_sat  = 1'b0;
`endif

endmodule

// File: tb/tb_dsp38_z_collector.sv
// Directed bench for dsp38_z_collector: LATENCY=0 and LATENCY=2 instances
// with DEPTH=4, a LATENCY=2/DEPTH=8 instance for the reset scenario, and a
// signed instance when DSP38_Z_SAT_EN is defined.
module tb_dsp38_z_collector;

`ifdef DSP38_Z_SAT_EN
  localparam int OUT_W = 20;
  localparam logic [OUT_W-1:0] T1_SECOND = 20'hFFFFF;
  localparam logic             T1_SECOND_SAT = 1'b1;
`else
  localparam int OUT_W = 38;
  localparam logic [OUT_W-1:0] T1_SECOND = 38'h3F_FFFF_FFF0;
  localparam logic             T1_SECOND_SAT = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT a: LATENCY=0, DEPTH=4 ----------------
  logic             a_in_valid, a_issue_ready, a_out_valid, a_out_ready;
  logic             a_out_sat, a_overflow;
  logic [37:0]      a_z;
  logic [OUT_W-1:0] a_out_data;
  logic [2:0]       a_count;

  dsp38_z_collector #(.LATENCY(0), .DEPTH(4), .Z_SIGNED(0), .SAT_W(20)) dut_a (
    .clk(clk), .reset(reset), .in_valid(a_in_valid), .issue_ready(a_issue_ready),
    .z(a_z), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_sat(a_out_sat), .count(a_count),
    .overflow(a_overflow));

  // ---------------- DUT b: LATENCY=2, DEPTH=4 ----------------
  logic             b_in_valid, b_issue_ready, b_out_valid, b_out_ready;
  logic             b_out_sat, b_overflow;
  logic [37:0]      b_op, b_d1, b_d2;
  logic [OUT_W-1:0] b_out_data;
  logic [2:0]       b_count;

  dsp38_z_collector #(.LATENCY(2), .DEPTH(4), .Z_SIGNED(0), .SAT_W(20)) dut_b (
    .clk(clk), .reset(reset), .in_valid(b_in_valid), .issue_ready(b_issue_ready),
    .z(b_d2), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_sat(b_out_sat), .count(b_count),
    .overflow(b_overflow));

  // ---------------- DUT c: LATENCY=2, DEPTH=8 ----------------
  logic             c_in_valid, c_issue_ready, c_out_valid, c_out_ready;
  logic             c_out_sat, c_overflow;
  logic [37:0]      c_op, c_d1, c_d2;
  logic [OUT_W-1:0] c_out_data;
  logic [3:0]       c_count;

  dsp38_z_collector #(.LATENCY(2), .DEPTH(8), .Z_SIGNED(0), .SAT_W(20)) dut_c (
    .clk(clk), .reset(reset), .in_valid(c_in_valid), .issue_ready(c_issue_ready),
    .z(c_d2), .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_data(c_out_data), .out_sat(c_out_sat), .count(c_count),
    .overflow(c_overflow));

  // Two-stage DSP pipeline model: operands issued at cycle t yield z at t+2.
  always @(posedge clk) begin
    b_d1 <= b_op;
    b_d2 <= b_d1;
    c_d1 <= c_op;
    c_d2 <= c_d1;
  end

`ifdef DSP38_Z_SAT_EN
  // ---------------- DUT d: signed clamp, LATENCY=0 ----------------
  logic             d_in_valid, d_issue_ready, d_out_valid, d_out_ready;
  logic             d_out_sat, d_overflow;
  logic [37:0]      d_z;
  logic [OUT_W-1:0] d_out_data;
  logic [2:0]       d_count;

  dsp38_z_collector #(.LATENCY(0), .DEPTH(4), .Z_SIGNED(1), .SAT_W(20)) dut_d (
    .clk(clk), .reset(reset), .in_valid(d_in_valid), .issue_ready(d_issue_ready),
    .z(d_z), .out_valid(d_out_valid), .out_ready(d_out_ready),
    .out_data(d_out_data), .out_sat(d_out_sat), .count(d_count),
    .overflow(d_overflow));
`endif

  // ---------------- scoreboard ----------------
  logic [OUT_W-1:0] exp_q[$];
  int n_vec;
  int n_err;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled and inputs driven 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pop the scoreboard head and compare it against a DUT head value.
  task automatic check_head(input string tag, input logic [OUT_W-1:0] obs);
    if (exp_q.size() == 0) begin
      check({tag, "_queue_empty"}, 64'd1, 64'd0);
    end else begin
      check(tag, obs, exp_q.pop_front());
    end
  endtask

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int accepted;

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    a_in_valid = 0; a_out_ready = 0; a_z = '0;
    b_in_valid = 0; b_out_ready = 0; b_op = '0;
    c_in_valid = 0; c_out_ready = 0; c_op = '0;
`ifdef DSP38_Z_SAT_EN
    d_in_valid = 0; d_out_ready = 0; d_z = '0;
`endif
    repeat (3) step();
    reset = 1'b0;

    // ---- reset values ----
    check("rst_out_valid",   a_out_valid,   0);
    check("rst_count",       a_count,       0);
    check("rst_overflow",    a_overflow,    0);
    check("rst_issue_ready", a_issue_ready, 1);
    check("rst_out_data",    a_out_data,    0);
    check("rst_out_sat",     a_out_sat,     0);
    check("rst_b_ready",     b_issue_ready, 1);

    // ---- 1: LATENCY=0 back-to-back issue with out_ready=1 ----
    a_out_ready = 1;
    a_in_valid  = 1;
    a_z         = 38'h0_0000_0064;
    step();
    check("t1_first_data",  a_out_data,  38'h64);
    check("t1_first_valid", a_out_valid, 1);
    check("t1_first_count", a_count,     1);
    a_z = 38'h3F_FFFF_FFF0;
    step();
    check("t1_second_data",  a_out_data,  T1_SECOND);
    check("t1_second_sat",   a_out_sat,   T1_SECOND_SAT);
    check("t1_second_count", a_count,     1);
    a_in_valid = 0;
    step();
    check("t1_drained_count", a_count,     0);
    check("t1_drained_valid", a_out_valid, 0);

`ifdef DSP38_Z_SAT_EN
    // ---- 5: clamping, unsigned and signed ----
    a_in_valid = 1;
    a_z        = 38'h0_0012_3456;
    step();
    check("t5_uns_clamp_data", a_out_data, 20'hFFFFF);
    check("t5_uns_clamp_sat",  a_out_sat,  1);
    a_z = 38'h0_0000_0ABC;
    step();
    check("t5_uns_pass_data", a_out_data, 20'h00ABC);
    check("t5_uns_pass_sat",  a_out_sat,  0);
    a_in_valid  = 0;
    d_out_ready = 1;
    d_in_valid  = 1;
    d_z         = 38'h3F_FE00_0000;
    step();
    d_in_valid = 0;
    check("t5_sgn_clamp_data", d_out_data, 20'h80000);
    check("t5_sgn_clamp_sat",  d_out_sat,  1);
    step();
`endif

    // ---- 2: LATENCY=2, out_ready=0, issue while credit is available ----
    b_out_ready = 0;
    accepted    = 0;
    for (int i = 0; i < 8; i++) begin
      b_in_valid = b_issue_ready;
      b_op       = 38'h100 + 38'(i);
      if (b_issue_ready) begin
        exp_q.push_back(OUT_W'(b_op));
        accepted++;
      end
      step();
    end
    b_in_valid = 0;
    check("t2_accepted",    accepted,      4);
    check("t2_count_full",  b_count,       4);
    check("t2_issue_ready", b_issue_ready, 0);
    check("t2_overflow_0",  b_overflow,    0);
    b_in_valid = 1;
    b_op       = 38'hDEAD;
    step();
    b_in_valid = 0;
    check("t2_overflow_1",   b_overflow, 1);
    check("t2_count_stays",  b_count,    4);
    repeat (3) step();
    check("t2_dropped_never_lands", b_count, 4);

    // ---- 3: one pop from full; credit returns the following cycle ----
    b_out_ready = 1;
    check("t3_ready_same_cycle", b_issue_ready, 0);
    check_head("t3_head", b_out_data);
    step();
    b_out_ready = 0;
    check("t3_count",       b_count,       3);
    check("t3_ready_next",  b_issue_ready, 1);
    check("t3_hold_head",   b_out_data,    exp_q[0]);

    // ---- 4: simultaneous push and pop at count=2 ----
    b_out_ready = 1;
    check_head("t4_head_a", b_out_data);
    step();
    b_out_ready = 0;
    check("t4_count_2", b_count, 2);
    b_in_valid = 1;
    b_op       = 38'h4A4A;
    exp_q.push_back(OUT_W'(b_op));
    step();
    b_in_valid = 0;
    step();
    b_out_ready = 1;
    check_head("t4_head_b", b_out_data);
    step();
    b_out_ready = 0;
    check("t4_push_pop_count", b_count, 2);
    b_out_ready = 1;
    for (int i = 0; i < 6; i++) begin
      if (b_out_valid) check_head("t4_drain", b_out_data);
      step();
    end
    b_out_ready = 0;
    check("t4_drained_count", b_count, 0);
    check("t4_queue_empty",   exp_q.size(), 0);

    // ---- 6: reset with 2 in flight and 3 queued ----
    c_out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      c_in_valid = 1;
      c_op       = 38'h500 + 38'(i);
      step();
    end
    c_in_valid = 0;
    check("t6_pre_count", c_count,     3);
    check("t6_pre_valid", c_out_valid, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t6_count",       c_count,       0);
    check("t6_out_valid",   c_out_valid,   0);
    check("t6_issue_ready", c_issue_ready, 1);
    check("t6_overflow",    c_overflow,    0);
    check("t6_b_overflow",  b_overflow,    0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("t6_no_stale", c_out_valid, 0);
    end
    check("t6_count_after", c_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
